// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// SRAM-like request/response channel: a level request with address and write
// fields, answered by an address-accept pulse and a later data/response pulse.
// The same bundle is used for the fetch side, the data side and the shared
// memory port, so the arbiter sees three instances of it.
//
// Signals
//   req      requester -> slave   request, held until data_ok
//   wr       requester -> slave   1 = write, 0 = read
//   wstrb    requester -> slave   byte write strobes
//   addr     requester -> slave   address
//   wdata    requester -> slave   write data
//   addr_ok  slave -> requester   address accepted
//   data_ok  slave -> requester   transaction complete / read data valid
//   rdata    slave -> requester   read data
//
// Modports
//   master   the side that issues requests
//   slave    the side that answers them
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the CPU's single SRAM-like memory port between instruction fetch and
// the MEM-stage data access. One transaction is outstanding at a time. The
// winner's address and write fields are captured at grant and held on the
// shared port until the transaction completes, so requesters may change or
// drop their inputs mid-flight (pipeline flush) without disturbing the port.
//
// Data requests win by default. A 2-bit streak counter counts consecutive
// data grants made while a fetch was waiting; when it reaches 2 the pending
// fetch wins the next grant, which bounds fetch starvation.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   inst_port  fetch requester (slave view; its write fields are ignored)
//   data_port  MEM-stage requester (slave view)
//   mem_port   shared memory port towards the bridge (master view)
//
// Timing
//   IDLE : grant cycle, port req=0
//   ADDR : port req=1 until addr_ok; addr_ok with data_ok completes at once
//   WAIT : port req=0, waiting for data_ok
//   Handshake pulses are routed combinationally to the owning requester only.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_port_arbiter_if.slave        inst_port,
    mem_port_arbiter_if.slave        data_port,
    mem_port_arbiter_if.master       mem_port
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic       SEL_INST   = 1'b0;
    localparam logic       SEL_DATA   = 1'b1;
    localparam logic [1:0] STREAK_MAX = 2'd2;

    // ------------------------------------------------------------------
    // State and registered port fields
    // ------------------------------------------------------------------
    state_t            state_q,  state_d;
    logic              sel_q,    sel_d;
    logic [1:0]        streak_q, streak_d;
    logic              req_q,    req_d;
    logic              wr_q,     wr_d;
    logic [3:0]        wstrb_q,  wstrb_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;

    logic any_req;
    logic grant_data;
    logic own_addr_ok;
    logic own_data_ok;

    // The fetch side never writes; its write fields exist only because the
    // channel bundle is shared with the data side.
    logic unused_inst_fields;
    assign unused_inst_fields = ^{inst_port.wr, inst_port.wstrb, inst_port.wdata};

    assign any_req = inst_port.req | data_port.req;

    // Data wins unless it is absent, or the fetch has already waited out
    // two data grants in a row.
    assign grant_data = data_port.req & ~(inst_port.req & (streak_q == STREAK_MAX));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        sel_d       = sel_q;
        streak_d    = streak_q;
        req_d       = req_q;
        wr_d        = wr_q;
        wstrb_d     = wstrb_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        own_addr_ok = 1'b0;
        own_data_ok = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ADDR;
                    req_d   = 1'b1;
                    if (grant_data) begin
                        sel_d   = SEL_DATA;
                        addr_d  = data_port.addr;
                        wr_d    = data_port.wr;
                        wstrb_d = data_port.wr ? data_port.wstrb : 4'b0000;
                        wdata_d = data_port.wdata;
                        // Only data grants that bypass a waiting fetch count
                        // towards the streak.
                        if (inst_port.req) begin
                            streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX
                                                                : streak_q + 2'd1;
                        end else begin
                            streak_d = 2'd0;
                        end
                    end else begin
                        sel_d    = SEL_INST;
                        addr_d   = inst_port.addr;
                        wr_d     = 1'b0;
                        wstrb_d  = 4'b0000;
                        wdata_d  = '0;
                        streak_d = 2'd0;
                    end
                end
            end

            ADDR: begin
                // A response without an address accept is not meaningful yet.
                if (mem_port.addr_ok) begin
                    own_addr_ok = 1'b1;
                    req_d       = 1'b0;
                    if (mem_port.data_ok) begin
                        own_data_ok = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                if (mem_port.data_ok) begin
                    own_data_ok = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= SEL_INST;
            streak_q <= 2'd0;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            wstrb_q  <= 4'b0000;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            sel_q    <= sel_d;
            streak_q <= streak_d;
            req_q    <= req_d;
            wr_q     <= wr_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_port.req   = req_q;
    assign mem_port.wr    = wr_q;
    assign mem_port.wstrb = wstrb_q;
    assign mem_port.addr  = addr_q;
    assign mem_port.wdata = wdata_q;

    // Handshakes go to the owner only; state_q resets asynchronously, so
    // these drop immediately on reset as well.
    assign inst_port.addr_ok = own_addr_ok & (sel_q == SEL_INST);
    assign inst_port.data_ok = own_data_ok & (sel_q == SEL_INST);
    assign data_port.addr_ok = own_addr_ok & (sel_q == SEL_DATA);
    assign data_port.data_ok = own_data_ok & (sel_q == SEL_DATA);

    // Read data is broadcast; each requester qualifies it with its data_ok.
    assign inst_port.rdata = mem_port.rdata;
    assign data_port.rdata = mem_port.rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A table of per-cycle vectors covers the
// lone fetch, contention, zero-latency slave and flush cases; hand-written
// sequences cover the starvation limit and reset in the middle of a
// transaction. Inputs change on the falling edge; outputs are compared 1 ns
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_bus ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .inst_port (inst_bus),
        .data_port (data_bus),
        .mem_port  (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and the outputs expected during that cycle.
    // e_ok is {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}.
    typedef struct packed {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_wr;
        logic [3:0]  d_strb;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        s_aok;
        logic        s_dok;
        logic [31:0] s_rdata;
        logic        e_req;
        logic        e_wr;
        logic [3:0]  e_strb;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_ok;
    } vec_t;

    localparam int N_VEC = 19;
    vec_t vecs [N_VEC];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] observed();
        return {22'd0, mem_bus.req, mem_bus.wr, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata,
                inst_bus.addr_ok, inst_bus.data_ok, data_bus.addr_ok, data_bus.data_ok,
                inst_bus.rdata, data_bus.rdata};
    endfunction

    function automatic logic [159:0] expected(input vec_t v);
        return {22'd0, v.e_req, v.e_wr, v.e_strb, v.e_addr, v.e_wdata, v.e_ok,
                v.s_rdata, v.s_rdata};
    endfunction

    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk);
        inst_bus.req   = v.i_req;
        inst_bus.addr  = v.i_addr;
        data_bus.req   = v.d_req;
        data_bus.wr    = v.d_wr;
        data_bus.wstrb = v.d_strb;
        data_bus.addr  = v.d_addr;
        data_bus.wdata = v.d_wdata;
        mem_bus.addr_ok = v.s_aok;
        mem_bus.data_ok = v.s_dok;
        mem_bus.rdata   = v.s_rdata;
        #1;
        check($sformatf("vec%0d", idx), observed(), expected(v));
    endtask

    // Runs one transaction from the IDLE-cycle falling edge: address accepted
    // in the first ADDR cycle, response one cycle later. Returns at the
    // falling edge of the following IDLE cycle.
    task automatic run_txn(input logic exp_data, input logic [31:0] exp_addr, input string name);
        @(negedge clk);
        mem_bus.addr_ok = 1'b1;
        mem_bus.data_ok = 1'b0;
        #1;
        check({name, " grant"},
              {125'd0, inst_bus.addr_ok, data_bus.addr_ok, mem_bus.req, mem_bus.addr},
              {125'd0, ~exp_data, exp_data, 1'b1, exp_addr});
        @(negedge clk);
        mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b1;
        #1;
        check({name, " done"},
              {158'd0, inst_bus.data_ok, data_bus.data_ok},
              {158'd0, ~exp_data, exp_data});
        @(negedge clk);
        mem_bus.data_ok = 1'b0;
    endtask

    initial begin
        // Lone fetch: grant, addr_ok at t+1, data_ok at t+3
        vecs[0]  = '{1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 4'b0000};
        vecs[1]  = '{1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b0, 4'h0, 32'hBFC0_0000, 32'h0, 4'b1000};
        vecs[2]  = '{1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'hBFC0_0000, 32'h0, 4'b0000};
        vecs[3]  = '{1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h2408_0001,
                     1'b0, 1'b0, 4'h0, 32'hBFC0_0000, 32'h0, 4'b0100};
        vecs[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'hBFC0_0000, 32'h0, 4'b0000};
        // Contention: data write wins; stray data_ok in ADDR and addr_ok in WAIT ignored
        vecs[5]  = '{1'b1, 32'hBFC0_0004, 1'b1, 1'b1, 4'b0011, 32'h8000_0010, 32'h0000_BEEF, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'hBFC0_0000, 32'h0, 4'b0000};
        vecs[6]  = '{1'b1, 32'hBFC0_0004, 1'b1, 1'b1, 4'b0011, 32'h8000_0010, 32'h0000_BEEF, 1'b0, 1'b1, 32'h5555_5555,
                     1'b1, 1'b1, 4'b0011, 32'h8000_0010, 32'h0000_BEEF, 4'b0000};
        vecs[7]  = '{1'b1, 32'hBFC0_0004, 1'b1, 1'b1, 4'b0011, 32'h8000_0010, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b1, 4'b0011, 32'h8000_0010, 32'h0000_BEEF, 4'b0010};
        vecs[8]  = '{1'b1, 32'hBFC0_0004, 1'b1, 1'b1, 4'b0011, 32'h8000_0010, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0,
                     1'b0, 1'b1, 4'b0011, 32'h8000_0010, 32'h0000_BEEF, 4'b0000};
        vecs[9]  = '{1'b1, 32'hBFC0_0004, 1'b1, 1'b1, 4'b0011, 32'h8000_0010, 32'h0000_BEEF, 1'b0, 1'b1, 32'h0,
                     1'b0, 1'b1, 4'b0011, 32'h8000_0010, 32'h0000_BEEF, 4'b0001};
        vecs[10] = '{1'b1, 32'hBFC0_0004, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b1, 4'b0011, 32'h8000_0010, 32'h0000_BEEF, 4'b0000};
        // Zero-latency slave on the fetch granted after the data write
        vecs[11] = '{1'b1, 32'hBFC0_0004, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h3C1D_0000,
                     1'b1, 1'b0, 4'h0, 32'hBFC0_0004, 32'h0, 4'b1100};
        vecs[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'hBFC0_0004, 32'h0, 4'b0000};
        // Flush: data read granted, requester drops and scrambles its inputs in WAIT
        vecs[13] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h8000_0020, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'hBFC0_0004, 32'h0, 4'b0000};
        vecs[14] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h8000_0020, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b0, 4'h0, 32'h8000_0020, 32'hDEAD_BEEF, 4'b0010};
        vecs[15] = '{1'b0, 32'h0, 1'b0, 1'b1, 4'h5, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'h8000_0020, 32'hDEAD_BEEF, 4'b0000};
        vecs[16] = '{1'b0, 32'h0, 1'b0, 1'b1, 4'h5, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D,
                     1'b0, 1'b0, 4'h0, 32'h8000_0020, 32'hDEAD_BEEF, 4'b0001};
        vecs[17] = '{1'b0, 32'h0, 1'b0, 1'b1, 4'h5, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'h8000_0020, 32'hDEAD_BEEF, 4'b0000};
        vecs[18] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'h8000_0020, 32'hDEAD_BEEF, 4'b0000};

        // Quiet inputs; the fetch channel's write fields are never used
        inst_bus.req   = 1'b0;
        inst_bus.wr    = 1'b0;
        inst_bus.wstrb = 4'h0;
        inst_bus.addr  = 32'h0;
        inst_bus.wdata = 32'h0;
        data_bus.req   = 1'b0;
        data_bus.wr    = 1'b0;
        data_bus.wstrb = 4'h0;
        data_bus.addr  = 32'h0;
        data_bus.wdata = 32'h0;
        mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b0;
        mem_bus.rdata   = 32'h0;

        // Reset state, with a request pending that must not be granted
        rst = 1'b1;
        @(negedge clk);
        inst_bus.req  = 1'b1;
        inst_bus.addr = 32'h1234_5678;
        @(negedge clk);
        #1;
        check("reset state", observed(), 160'd0);
        inst_bus.req  = 1'b0;
        inst_bus.addr = 32'h0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
            apply_vec(vecs[i], i);
        end

        // Starvation limit: both requesters stay up; expect D, D, I, D, D, I
        @(negedge clk);
        inst_bus.req   = 1'b1;
        inst_bus.addr  = 32'hBFC0_0200;
        data_bus.req   = 1'b1;
        data_bus.wr    = 1'b0;
        data_bus.wstrb = 4'h0;
        data_bus.addr  = 32'h8000_0040;
        data_bus.wdata = 32'h0;
        run_txn(1'b1, 32'h8000_0040, "starve g1");
        run_txn(1'b1, 32'h8000_0040, "starve g2");
        run_txn(1'b0, 32'hBFC0_0200, "starve g3");
        run_txn(1'b1, 32'h8000_0040, "starve g4");
        run_txn(1'b1, 32'h8000_0040, "starve g5");
        run_txn(1'b0, 32'hBFC0_0200, "starve g6");

        // Reset in WAIT after two data grants have built up the streak
        data_bus.wr    = 1'b1;
        data_bus.wstrb = 4'hF;
        data_bus.addr  = 32'h8000_0030;
        data_bus.wdata = 32'h1111_2222;
        run_txn(1'b1, 32'h8000_0030, "rst pre");
        @(negedge clk);
        mem_bus.addr_ok = 1'b1;
        #1;
        check("rst addr phase",
              {118'd0, data_bus.addr_ok, mem_bus.req, mem_bus.wr, mem_bus.wstrb, mem_bus.wdata},
              {118'd0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h1111_2222});
        @(negedge clk);
        mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b1;
        #1;
        check("rst wait pre", {159'd0, data_bus.data_ok}, {159'd0, 1'b1});
        #1;
        rst = 1'b1;
        #1;
        check("rst async clear",
              {86'd0, mem_bus.req, mem_bus.wr, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata,
               inst_bus.addr_ok, inst_bus.data_ok, data_bus.addr_ok, data_bus.data_ok},
              160'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_bus.data_ok = 1'b0;
        // Streak restarted at 0, so data wins again over the waiting fetch
        run_txn(1'b1, 32'h8000_0030, "post rst data");
        data_bus.req = 1'b0;
        run_txn(1'b0, 32'hBFC0_0200, "post rst inst");
        inst_bus.req = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the CPU's single SRAM-like memory port between instruction fetch (IF) and data access (MEM). It holds one outstanding transaction at a time and latches the winning requester's address and write fields at grant. It forwards the slave's address/data handshakes back to the owning requester. Data requests win by default; a streak limit prevents fetch starvation. It sits between the pipeline's fetch/memory stages and the external memory bridge.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- inst_req  in  1  fetch request, level; held until inst_data_ok
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch address accepted by slave
- inst_data_ok  out  1  fetch data valid on inst_rdata
- inst_rdata  out  DATA_W  fetch read data
- data_req  in  1  MEM-stage request, level; held until data_data_ok
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  4  byte write strobes
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  data transaction complete; read data valid
- data_rdata  out  DATA_W  data read data
- req  out  1  shared-port request
- wr  out  1  shared-port write
- wstrb  out  4  shared-port strobes
- addr  out  ADDR_W  shared-port address
- wdata  out  DATA_W  shared-port write data
- addr_ok  in  1  slave accepted address
- data_ok  in  1  slave response valid
- rdata  in  DATA_W  slave read data

## Operation
- FSM states: IDLE, ADDR, WAIT. A 1-bit `sel` register records the owner (0 = inst, 1 = data).
- **IDLE:** if any request is pending, grant, latch the owner's fields into the port registers, and go to ADDR.
  - Default grant goes to data.
  - Inst wins when data_req=0, or when streak==2 and inst_req=1.
- **Streak counter (2 bits):**
  - +1 on each data grant made while inst_req=1.
  - Cleared on an inst grant, and on a data grant made while inst_req=0.
  - Saturates at 2.
- **Latched port fields:**
  - addr: the owner's address.
  - wr: data_wr for data; 0 for inst.
  - wstrb: data_wstrb when wr=1, else 0.
  - wdata: data_wdata for data; 0 for inst.
- **ADDR:** req=1.
  - addr_ok=1 → pulse the owner's *_addr_ok in the same cycle (combinational) and go to WAIT.
  - addr_ok=1 and data_ok=1 in the same cycle → also pulse *_data_ok, drop req, and go to IDLE.
  - data_ok without addr_ok in ADDR is ignored.
- **WAIT:** req=0.
  - data_ok=1 → pulse the owner's *_data_ok in the same cycle and go to IDLE.
  - addr_ok in WAIT is ignored.
- inst_rdata = data_rdata = rdata, combinational and unconditional; valid only while the corresponding *_data_ok is high.
- A requester dropping its req mid-transaction (pipeline flush) does not abort the transaction. It completes, and *_data_ok still pulses; the requester discards it.
- The non-owner's *_addr_ok and *_data_ok are always 0.

## Timing
- Reset (async, immediate) values:
  - state=IDLE, sel=0, streak=0.
  - req, wr, wstrb, addr, wdata all 0.
  - All *_addr_ok and *_data_ok = 0.
- A request seen in IDLE at cycle t produces req=1 at t+1.
- Minimum transaction is 2 cycles (grant, then ADDR with addr_ok and data_ok together). The typical slave takes 3+ cycles.
- After completion there is exactly one IDLE (grant) cycle before the next req. Port throughput is at most one transaction per 2 cycles.
- Port fields are stable from grant until the transaction completes, independent of requester inputs.
- Reset asserted mid-transaction: req drops immediately, and any in-flight slave response is lost. The bridge is reset by the same rst.
- Simultaneous inst_req and data_req in IDLE: resolved by the priority and streak rules above.

## Test plan
- **Lone fetch:** inst_req=1, inst_addr=0xBFC00000; slave addr_ok at t+1, data_ok at t+3 with rdata=0x24080001.
  - Expect req=1 only at t+1 with addr=0xBFC00000, wr=0.
  - Expect inst_addr_ok at t+1 and inst_data_ok at t+3 with inst_rdata=0x24080001.
  - Expect data_* ok signals to stay 0.
- **Contention:** inst_req=1 and data_req=1 (write to 0x80000010, wstrb=4'b0011, wdata=0x0000BEEF) raised together.
  - Data is granted first: wr=1, wstrb=0011, wdata=0x0000BEEF.
  - Inst is granted in the IDLE cycle after data_data_ok.
- **Starvation limit:** inst_req held high while data_req is re-raised immediately after each data completion.
  - Grant order must be data, data, inst, data, data, inst.
- **Zero-latency slave:** addr_ok=1 and data_ok=1 in the same ADDR cycle.
  - Both *_addr_ok and *_data_ok pulse that cycle; the FSM is back in IDLE next cycle.
- **Flush mid-transaction:** data_req drops in WAIT after a read grant to 0x80000020.
  - The transaction still completes and data_data_ok pulses on data_ok.
  - addr and wdata stay unchanged throughout.
- **Reset mid-transaction:** rst pulsed in WAIT.
  - req, addr, and all ok outputs go to 0 without waiting for a clock edge.
  - After release, a new inst_req is granted normally and streak restarts at 0.
